// File: rtl/zelda_sprite_engine.sv
// Walking-sprite compositor: overlays one animated, direction-facing sprite on the
// background pixel stream and flags wall contact on the sprite's leading edge per frame.
module zelda_sprite_engine #(
  parameter int          SPRITE_W       = 32,
  parameter int          SPRITE_H       = 32,
  parameter int          FRAMES_PER_DIR = 2,
  parameter int          FRAME_PERIOD   = 8,
  parameter logic [3:0]  TRANSP_IDX     = 4'h0,
  parameter logic [11:0] WALL0          = 12'hB47,
  parameter logic [11:0] WALL1          = 12'hD8A,
  parameter logic [11:0] WALL2          = 12'hFCC,
  localparam int         ADDR_W         = $clog2(4 * FRAMES_PER_DIR * SPRITE_W * SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        spriteX,
  input  logic [9:0]        spriteY,
  input  logic [7:0]        keycode,
  output logic [ADDR_W-1:0] spr_addr,
  input  logic [3:0]        spr_idx,
  input  logic [11:0]       spr_rgb,
  input  logic [11:0]       bg_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              collision,
  output logic [1:0]        dir
);

  localparam int FW = (FRAMES_PER_DIR > 1) ? $clog2(FRAMES_PER_DIR) : 1;
  localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Frame-level state, updated only at frame start.
  logic [9:0]    spx_q, spx_d;
  logic [9:0]    spy_q, spy_d;
  dir_e          dir_q, dir_d;
  logic          moving_q, moving_d;
  logic [FW-1:0] anim_frame_q, anim_frame_d;
  logic [CW-1:0] anim_cnt_q, anim_cnt_d;
  logic          coll_acc_q, coll_acc_d;
  logic          collision_q, collision_d;

  // Pixel pipeline.
  logic          in_box_q, in_box_d;
  logic          probe_q, probe_d;
  logic          blank_q, blank_d;
  logic [11:0]   rgb_q, rgb_d;

  logic          fs;
  logic          key_valid;
  dir_e          key_dir;
  logic [9:0]    dx, dy;
  logic [10:0]   x_ext, y_ext, sx_ext, sy_ext;
  logic          in_box;
  logic          edge_match;
  logic          hit_s1;
  logic [ADDR_W-1:0] frame_sel;

  assign fs = (DrawX == 10'd0) && (DrawY == 10'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    key_valid = 1'b1;
    key_dir   = DIR_DOWN;
    case (keycode)
      8'h07:   key_dir = DIR_RIGHT;
      8'h1A:   key_dir = DIR_UP;
      8'h04:   key_dir = DIR_LEFT;
      8'h16:   key_dir = DIR_DOWN;
      default: key_valid = 1'b0;
    endcase
  end

  // Box test in 11 bits so a sprite hanging off the right/bottom is clipped, not wrapped.
  always_comb begin
    dx     = DrawX - spx_q;
    dy     = DrawY - spy_q;
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    sx_ext = {1'b0, spx_q};
    sy_ext = {1'b0, spy_q};
    in_box = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPRITE_W)) &&
             (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPRITE_H));
  end

  always_comb begin
    frame_sel = ADDR_W'(dir_q) * ADDR_W'(FRAMES_PER_DIR) + ADDR_W'(anim_frame_q);
    spr_addr  = (frame_sel * ADDR_W'(SPRITE_H) + ADDR_W'(dy)) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);
  end

  always_comb begin
    edge_match = 1'b0;
    case (dir_q)
      DIR_RIGHT: edge_match = (dx == 10'(SPRITE_W - 1));
      DIR_LEFT:  edge_match = (dx == 10'd0);
      DIR_UP:    edge_match = (dy == 10'd0);
      DIR_DOWN:  edge_match = (dy == 10'(SPRITE_H - 1));
      default:   edge_match = 1'b0;
    endcase
  end

  assign hit_s1 = probe_q &&
                  ((bg_rgb == WALL0) || (bg_rgb == WALL1) || (bg_rgb == WALL2));

  always_comb begin
    spx_d        = spx_q;
    spy_d        = spy_q;
    dir_d        = dir_q;
    moving_d     = moving_q;
    anim_frame_d = anim_frame_q;
    anim_cnt_d   = anim_cnt_q;
    collision_d  = collision_q;
    coll_acc_d   = coll_acc_q | hit_s1;

    if (fs) begin
      spx_d       = spriteX;
      spy_d       = spriteY;
      moving_d    = key_valid;
      // A hit landing on the frame-start cycle was probed in the previous frame.
      collision_d = coll_acc_q | hit_s1;
      coll_acc_d  = 1'b0;
      if (key_valid) begin
        dir_d = key_dir;
        if (anim_cnt_q == CW'(FRAME_PERIOD - 1)) begin
          anim_cnt_d   = '0;
          anim_frame_d = (anim_frame_q == FW'(FRAMES_PER_DIR - 1)) ? '0 : anim_frame_q + 1'b1;
        end else begin
          anim_cnt_d = anim_cnt_q + 1'b1;
        end
      end else begin
        anim_cnt_d   = '0;
        anim_frame_d = '0;
      end
    end
  end

  always_comb begin
    in_box_d = in_box;
    probe_d  = in_box && blank && moving_q && edge_match;
    blank_d  = blank;
    if (!blank_q) begin
      rgb_d = 12'h000;
    end else if (in_box_q && (spr_idx != TRANSP_IDX)) begin
      rgb_d = spr_rgb;
    end else begin
      rgb_d = bg_rgb;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      spx_q        <= '0;
      spy_q        <= '0;
      dir_q        <= DIR_DOWN;
      moving_q     <= 1'b0;
      anim_frame_q <= '0;
      anim_cnt_q   <= '0;
      coll_acc_q   <= 1'b0;
      collision_q  <= 1'b0;
      in_box_q     <= 1'b0;
      probe_q      <= 1'b0;
      blank_q      <= 1'b0;
      rgb_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      spx_q        <= spx_d;
      spy_q        <= spy_d;
      dir_q        <= dir_d;
      moving_q     <= moving_d;
      anim_frame_q <= anim_frame_d;
      anim_cnt_q   <= anim_cnt_d;
      coll_acc_q   <= coll_acc_d;
      collision_q  <= collision_d;
      in_box_q     <= in_box_d;
      probe_q      <= probe_d;
      blank_q      <= blank_d;
      rgb_q        <= rgb_d;
    end
  end

  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign collision = collision_q;
  assign dir       = dir_q;

endmodule

// File: tb/tb_zelda_sprite_engine.sv
// Directed bench for zelda_sprite_engine: short synthetic "frames" (a single (0,0) cycle
// marks frame start) drive compositing vectors plus collision/animation/reset sequences.
module tb_zelda_sprite_engine;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, spriteX, spriteY;
  logic        blank;
  logic [7:0]  keycode;
  logic [12:0] spr_addr;
  logic [3:0]  spr_idx;
  logic [11:0] spr_rgb, bg_rgb;
  logic [3:0]  red, green, blue;
  logic        collision;
  logic [1:0]  dir;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [9:0] IX = 10'd700;
  localparam logic [9:0] IY = 10'd600;

  zelda_sprite_engine dut (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .blank    (blank),
    .spriteX  (spriteX),
    .spriteY  (spriteY),
    .keycode  (keycode),
    .spr_addr (spr_addr),
    .spr_idx  (spr_idx),
    .spr_rgb  (spr_rgb),
    .bg_rgb   (bg_rgb),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .collision(collision),
    .dir      (dir)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [9:0]  spx, spy, x, y;
    logic        bl;
    logic [3:0]  idx;
    logic [11:0] srgb, bg, exp_rgb;
    logic        chk_addr;
    logic [12:0] exp_addr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // One pixel cycle; bg/idx/srgb belong to the pixel driven in the previous cycle.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic bl,
                     input logic [11:0] bg, input logic [3:0] idx, input logic [11:0] srgb);
    DrawX = x; DrawY = y; blank = bl;
    bg_rgb = bg; spr_idx = idx; spr_rgb = srgb;
    tick();
  endtask

  task automatic fstart(input logic [9:0] sx, input logic [9:0] sy,
                        input logic [7:0] key, input logic [11:0] bg);
    spriteX = sx; spriteY = sy; keycode = key;
    pix(10'd0, 10'd0, 1'b0, bg, 4'h0, 12'h000);
  endtask

  task automatic check_addr_at(input string name, input logic [9:0] x, input logic [9:0] y,
                               input logic [12:0] exp);
    DrawX = x; DrawY = y; blank = 1'b0;
    #1;
    check(name, 32'(spr_addr), 32'(exp));
    tick();
  endtask

  initial begin
    logic [12:0] exp_a;

    // spx spy x y bl idx srgb bg exp_rgb chk_addr exp_addr
    vecs[0]  = '{10'd100, 10'd50, 10'd110, 10'd60, 1'b1, 4'h0, 12'hF00, 12'h123, 12'h123, 1'b1, 13'd330};
    vecs[1]  = '{10'd100, 10'd50, 10'd110, 10'd60, 1'b1, 4'h5, 12'hF00, 12'h123, 12'hF00, 1'b1, 13'd330};
    vecs[2]  = '{10'd100, 10'd50, 10'd99,  10'd60, 1'b1, 4'h5, 12'hF00, 12'h123, 12'h123, 1'b0, 13'd0};
    vecs[3]  = '{10'd100, 10'd50, 10'd131, 10'd81, 1'b1, 4'h5, 12'h0A5, 12'h123, 12'h0A5, 1'b1, 13'd1023};
    vecs[4]  = '{10'd100, 10'd50, 10'd132, 10'd60, 1'b1, 4'h5, 12'h0A5, 12'h456, 12'h456, 1'b0, 13'd0};
    vecs[5]  = '{10'd100, 10'd50, 10'd110, 10'd82, 1'b1, 4'h5, 12'h0A5, 12'h456, 12'h456, 1'b0, 13'd0};
    vecs[6]  = '{10'd100, 10'd50, 10'd110, 10'd60, 1'b0, 4'h5, 12'hF00, 12'h123, 12'h000, 1'b1, 13'd330};
    vecs[7]  = '{10'd620, 10'd0,  10'd639, 10'd5,  1'b1, 4'h7, 12'h777, 12'h321, 12'h777, 1'b1, 13'd179};
    vecs[8]  = '{10'd620, 10'd0,  10'd5,   10'd5,  1'b1, 4'h7, 12'h777, 12'h321, 12'h321, 1'b0, 13'd0};
    vecs[9]  = '{10'd620, 10'd0,  10'd11,  10'd5,  1'b1, 4'h7, 12'h777, 12'h321, 12'h321, 1'b0, 13'd0};
    vecs[10] = '{10'd0,   10'd0,  10'd1,   10'd0,  1'b1, 4'h3, 12'h0F0, 12'h321, 12'h0F0, 1'b1, 13'd1};
    vecs[11] = '{10'd1000,10'd470,10'd1023,10'd479,1'b1, 4'h9, 12'hA5A, 12'h321, 12'hA5A, 1'b1, 13'd311};
    vecs[12] = '{10'd1000,10'd470,10'd3,   10'd475,1'b1, 4'h9, 12'hA5A, 12'h321, 12'h321, 1'b0, 13'd0};

    reset_n = 1'b0;
    DrawX = IX; DrawY = IY; blank = 1'b0;
    spriteX = '0; spriteY = '0; keycode = 8'h00;
    spr_idx = '0; spr_rgb = '0; bg_rgb = '0;
    #1;
    check("reset rgb", 32'({red, green, blue}), 32'h0);
    check("reset collision", 32'(collision), 32'h0);
    check("reset dir", 32'(dir), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Compositing / clipping vectors, sprite facing down, idle.
    for (int i = 0; i < 13; i++) begin
      fstart(vecs[i].spx, vecs[i].spy, 8'h00, 12'h000);
      DrawX = vecs[i].x; DrawY = vecs[i].y; blank = vecs[i].bl;
      #1;
      if (vecs[i].chk_addr)
        check($sformatf("v%0d addr", i), 32'(spr_addr), 32'(vecs[i].exp_addr));
      tick();
      pix(IX, IY, 1'b0, vecs[i].bg, vecs[i].idx, vecs[i].srgb);
      check($sformatf("v%0d rgb", i), 32'({red, green, blue}), 32'(vecs[i].exp_rgb));
    end

    // Facing: left for one frame, then released; mid-frame keys ignored.
    fstart(10'd100, 10'd50, 8'h04, 12'h000);
    check("t3 dir left", 32'(dir), 32'd2);
    check_addr_at("t3 addr left", 10'd100, 10'd50, 13'd4096);
    fstart(10'd100, 10'd50, 8'h00, 12'h000);
    check("t3 dir held", 32'(dir), 32'd2);
    check_addr_at("t3 addr held", 10'd100, 10'd50, 13'd4096);
    keycode = 8'h07;
    pix(IX, IY, 1'b0, 12'h000, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'h000, 4'h0, 12'h000);
    check("t3 midframe key", 32'(dir), 32'd2);

    // Animation: right held for 24 frames, step every 8 frames.
    for (int k = 1; k <= 24; k++) begin
      fstart(10'd100, 10'd50, 8'h07, 12'h000);
      exp_a = 13'((((6 + ((k / 8) % 2)) * 32) + 3) * 32 + 5);
      check_addr_at($sformatf("t4 addr fs%0d", k), 10'd105, 10'd53, exp_a);
    end
    fstart(10'd100, 10'd50, 8'h00, 12'h000);
    check_addr_at("t4 addr release", 10'd105, 10'd53, 13'd6245);
    check("t4 dir held", 32'(dir), 32'd3);

    // Collision on the right leading edge.
    fstart(10'd100, 10'd50, 8'h07, 12'h000);
    check("t5 pre", 32'(collision), 32'd0);
    pix(10'd131, 10'd60, 1'b1, 12'h000, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'hB47, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'h000, 4'h0, 12'h000);
    check("t5 mid frame", 32'(collision), 32'd0);
    fstart(10'd100, 10'd50, 8'h07, 12'h000);
    check("t5 hit", 32'(collision), 32'd1);
    pix(10'd100, 10'd60, 1'b1, 12'h000, 4'h0, 12'h000);
    pix(10'd131, 10'd61, 1'b1, 12'hB47, 4'h0, 12'h000);
    pix(10'd131, 10'd62, 1'b0, 12'h123, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'hB47, 4'h0, 12'h000);
    check("t5 held", 32'(collision), 32'd1);
    fstart(10'd100, 10'd50, 8'h07, 12'h000);
    check("t5 non-edge", 32'(collision), 32'd0);
    pix(10'd131, 10'd60, 1'b1, 12'h000, 4'h0, 12'h000);
    fstart(10'd100, 10'd50, 8'h00, 12'hD8A);
    check("t5 fs hit", 32'(collision), 32'd1);
    fstart(10'd100, 10'd50, 8'h00, 12'h000);
    check("t5 fs fold", 32'(collision), 32'd0);
    pix(10'd131, 10'd60, 1'b1, 12'h000, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'hB47, 4'h0, 12'h000);
    fstart(10'd100, 10'd50, 8'h07, 12'h000);
    check("t5 idle", 32'(collision), 32'd0);
    pix(10'd131, 10'd81, 1'b1, 12'h000, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'hFCC, 4'h0, 12'h000);
    fstart(10'd100, 10'd50, 8'h07, 12'h000);
    check("t5 wall2", 32'(collision), 32'd1);

    // Mid-line asynchronous reset.
    pix(10'd110, 10'd60, 1'b1, 12'h000, 4'h0, 12'h000);
    pix(IX, IY, 1'b0, 12'h000, 4'h5, 12'hABC);
    check("rst pre rgb", 32'({red, green, blue}), 32'hABC);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst async rgb", 32'({red, green, blue}), 32'h0);
    check("rst async collision", 32'(collision), 32'd0);
    check("rst async dir", 32'(dir), 32'd0);
    keycode = 8'h00;
    tick();
    reset_n = 1'b1;
    keycode = 8'h04;
    tick(); tick();
    check("rst hold dir", 32'(dir), 32'd0);
    check("rst hold collision", 32'(collision), 32'd0);
    fstart(10'd100, 10'd50, 8'h04, 12'h000);
    check("rst first fs dir", 32'(dir), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
